// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM bus between instruction fetch
// and the load/store buffer, serialising 32-bit requests into bytes.
module mem_arbiter (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  nbytes_q, nbytes_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic        src_if_q, src_if_d;
    logic        last_if_q, last_if_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        if_done_q, if_done_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic        grant_if, grant_ls;
    logic [31:0] sel_addr;
    logic [2:0]  nxt;
    logic [31:0] nxt_a;
    logic [1:0]  lane;
    logic [7:0]  wbyte;
    logic [31:0] asm;

    function automatic logic is_io(input logic [31:0] a);
        return a[17:16] == 2'b11;
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] s);
        case (s)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // On a tie the requester that did not win last time gets the bus
    assign grant_if = if_req && (!ls_req || !last_if_q);
    assign grant_ls = ls_req && (!if_req || last_if_q);
    assign sel_addr = grant_if ? if_addr : ls_addr;

    assign nxt   = cnt_q + 3'd1;
    assign nxt_a = base_q + {29'd0, nxt};
    assign lane  = 2'(cnt_q - 3'd1);
    assign wbyte = wdata_q[{nxt[1:0], 3'b000} +: 8];

    // Merge the byte arriving this cycle into the assembly buffer
    always_comb begin
        asm = buf_q;
        asm[{lane, 3'b000} +: 8] = mem_din;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nbytes_d   = nbytes_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        src_if_d   = src_if_q;
        last_if_d  = last_if_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        case (state_q)
            IDLE: begin
                mem_wr_d = 1'b0;
                if (!clear && !if_done_q && !ls_done_q
                    && (grant_if || grant_ls)) begin
                    cnt_d     = 3'd0;
                    buf_d     = 32'd0;
                    base_d    = sel_addr;
                    wdata_d   = ls_wdata;
                    src_if_d  = grant_if;
                    last_if_d = grant_if;
                    mem_a_d   = sel_addr;
                    nbytes_d  = grant_if ? 3'd4 : size_bytes(ls_size);
                    if (grant_ls && ls_wr) begin
                        state_d    = WRITE;
                        mem_dout_d = ls_wdata[7:0];
                        mem_wr_d   = !(is_io(ls_addr) && io_buffer_full);
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                mem_wr_d = 1'b0;
                if (clear) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = nxt;
                    if (nxt < nbytes_q)
                        mem_a_d = nxt_a;
                    if (cnt_q != 3'd0)
                        buf_d = asm;
                    if (cnt_q == nbytes_q) begin
                        state_d = IDLE;
                        if (src_if_q) begin
                            if_data_d = asm;
                            if_done_d = 1'b1;
                        end else begin
                            ls_rdata_d = asm;
                            ls_done_d  = 1'b1;
                        end
                    end
                end
            end
            WRITE: begin
                if (mem_wr_q) begin
                    if (nxt < nbytes_q) begin
                        cnt_d      = nxt;
                        mem_a_d    = nxt_a;
                        mem_dout_d = wbyte;
                        mem_wr_d   = !(is_io(nxt_a) && io_buffer_full);
                    end else begin
                        state_d   = IDLE;
                        mem_wr_d  = 1'b0;
                        ls_done_d = 1'b1;
                    end
                end else begin
                    mem_wr_d = !(is_io(mem_a_q) && io_buffer_full);
                end
            end
            default: begin
                state_d  = IDLE;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    // State register; rdy_in low freezes everything
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            nbytes_q   <= 3'd0;
            base_q     <= 32'd0;
            wdata_q    <= 32'd0;
            buf_q      <= 32'd0;
            src_if_q   <= 1'b0;
            last_if_q  <= 1'b1;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= 32'd0;
            ls_rdata_q <= 32'd0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nbytes_q   <= nbytes_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            src_if_q   <= src_if_d;
            last_if_q  <= last_if_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q;
    assign if_done  = if_done_q;
    assign ls_done  = ls_done_q;
    assign if_data  = if_data_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a byte RAM
// model that registers its read data and freezes with rdy_in.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear, io_buffer_full;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req, ls_wr;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;

    mem_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .clear(clear), .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done), .if_data(if_data), .ls_req(ls_req),
        .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic        is_if;
        logic        chk;
        logic [31:0] data;
        logic [31:0] due;
    } exp_t;

    exp_t sb[$];
    int   nchk = 0;
    int   nfail = 0;
    int   seen = 0;
    int   wr_cnt = 0;
    int   cyc = 0;
    logic en_q = 1'b0;
    logic loaded = 1'b0;
    logic [7:0] ram [0:262143];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic is_if, input logic chk,
                        input logic [31:0] data, input int due);
        exp_t e;
        e.is_if = is_if;
        e.chk   = chk;
        e.data  = data;
        e.due   = 32'(due);
        sb.push_back(e);
    endtask

    task automatic take(input logic src);
        exp_t e;
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("done_src", 32'(src), 32'(e.is_if));
            check("done_edge", 32'(cyc), e.due);
            if (e.chk)
                check("done_data", src ? if_data : ls_rdata, e.data);
        end
        seen++;
    endtask

    // Synchronous byte RAM with registered read data
    always @(posedge clk_in) begin
        if (!loaded) begin
            ram[18'h00021] <= 8'hCD;
            ram[18'h00100] <= 8'h13;
            ram[18'h00101] <= 8'h00;
            ram[18'h00102] <= 8'h50;
            ram[18'h00103] <= 8'h00;
            ram[18'h00104] <= 8'h78;
            ram[18'h00105] <= 8'h56;
            ram[18'h00106] <= 8'h34;
            ram[18'h00107] <= 8'h12;
            ram[18'h00200] <= 8'h11;
            ram[18'h00201] <= 8'h22;
            ram[18'h00202] <= 8'h33;
            ram[18'h00203] <= 8'h44;
            loaded <= 1'b1;
        end else if (rdy_in) begin
            if (mem_wr)
                ram[mem_a[17:0]] <= mem_dout;
            mem_din <= ram[mem_a[17:0]];
        end
    end

    // Edge counter and enabled-edge flag
    always @(posedge clk_in) begin
        cyc  <= cyc + 1;
        en_q <= rdy_in;
    end

    // Output monitor: pops the scoreboard on each done pulse
    always @(negedge clk_in) begin
        if (!rst_in && en_q) begin
            if (if_done) take(1'b1);
            if (ls_done) take(1'b0);
            if (mem_wr) wr_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_done(input int tgt, input string tag);
        for (int k = 0; k < 60 && seen < tgt; k++) tick();
        check(tag, 32'(seen), 32'(tgt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int w0;
        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
        io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = 32'd0;
        ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'd0;
        ls_addr = 32'd0; ls_wdata = 32'd0;
        idle(2);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_dout", 32'(mem_dout), 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_dones", 32'({if_done, ls_done}), 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_ls_rdata", ls_rdata, 32'd0);
        rst_in = 1'b0;
        tick();

        // tie from reset: LSB, IF, LSB, IF
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h200;
        g = cyc + 1;
        push(1'b0, 1'b1, 32'h44332211, g + 5);
        push(1'b1, 1'b1, 32'h00500013, g + 12);
        push(1'b0, 1'b1, 32'h44332211, g + 19);
        push(1'b1, 1'b1, 32'h00500013, g + 26);
        tick();
        check("tie_first_a", mem_a, 32'h200);
        wait_done(seen + 4, "tie_wait");
        if_req = 1'b0; ls_req = 1'b0;
        idle(2);

        // word fetch with address walk
        if_req = 1'b1; if_addr = 32'h100;
        g = cyc + 1;
        push(1'b1, 1'b1, 32'h00500013, g + 5);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("fetch_a", mem_a, 32'h100 + 32'(i));
            check("fetch_wr", 32'(mem_wr), 32'd0);
        end
        wait_done(seen + 1, "fetch_wait");
        if_req = 1'b0;
        idle(2);

        // byte store
        w0 = wr_cnt;
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0;
        ls_addr = 32'h20; ls_wdata = 32'h000000AB;
        g = cyc + 1;
        push(1'b0, 1'b0, 32'd0, g + 1);
        tick();
        check("st_wr", 32'(mem_wr), 32'd1);
        check("st_dout", 32'(mem_dout), 32'hAB);
        check("st_a", mem_a, 32'h20);
        wait_done(seen + 1, "st_wait");
        ls_req = 1'b0;
        idle(2);
        check("st_wr_cycles", 32'(wr_cnt - w0), 32'd1);
        check("st_ram", 32'(ram[18'h20]), 32'hAB);

        // half load
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd1; ls_addr = 32'h20;
        g = cyc + 1;
        push(1'b0, 1'b1, 32'h0000CDAB, g + 3);
        wait_done(seen + 1, "half_wait");
        ls_req = 1'b0;
        idle(2);

        // fetch aborted by clear two cycles in
        if_req = 1'b1; if_addr = 32'h100;
        idle(2);
        clear = 1'b1;
        tick();
        clear = 1'b0; if_req = 1'b0;
        check("flush_wr", 32'(mem_wr), 32'd0);
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h20;
        g = cyc + 1;
        push(1'b0, 1'b1, 32'h000000AB, g + 2);
        tick();
        check("flush_idle_a", mem_a, 32'h20);
        wait_done(seen + 1, "flush_wait");
        ls_req = 1'b0;
        idle(4);

        // clear during word store does not abort it
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2;
        ls_addr = 32'h40; ls_wdata = 32'hDEADBEEF;
        g = cyc + 1;
        push(1'b0, 1'b0, 32'd0, g + 4);
        idle(2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        wait_done(seen + 1, "wflush_wait");
        ls_req = 1'b0;
        idle(2);
        check("wflush_ram", {ram[18'h43], ram[18'h42],
                             ram[18'h41], ram[18'h40]}, 32'hDEADBEEF);

        // IO stall on a byte store
        io_buffer_full = 1'b1;
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0;
        ls_addr = 32'h30000; ls_wdata = 32'h0000005A;
        g = cyc + 1;
        push(1'b0, 1'b0, 32'd0, g + 4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("io_hold", 32'(mem_wr), 32'd0);
        end
        io_buffer_full = 1'b0;
        tick();
        check("io_wr", 32'(mem_wr), 32'd1);
        check("io_dout", 32'(mem_dout), 32'h5A);
        wait_done(seen + 1, "io_wait");
        ls_req = 1'b0;
        idle(2);
        check("io_ram", 32'(ram[18'h30000]), 32'h5A);

        // freeze for two cycles mid-fetch
        if_req = 1'b1; if_addr = 32'h104;
        g = cyc + 1;
        push(1'b1, 1'b1, 32'h12345678, g + 7);
        idle(2);
        rdy_in = 1'b0;
        idle(2);
        rdy_in = 1'b1;
        wait_done(seen + 1, "frz_wait");
        if_req = 1'b0;
        idle(2);

        // async reset in the middle of a store
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2;
        ls_addr = 32'h50; ls_wdata = 32'h01020304;
        idle(2);
        rst_in = 1'b1;
        #1;
        check("arst_wr", 32'(mem_wr), 32'd0);
        check("arst_a", mem_a, 32'd0);
        check("arst_dout", 32'(mem_dout), 32'd0);
        check("arst_if_data", if_data, 32'd0);
        check("arst_ls_rdata", ls_rdata, 32'd0);
        ls_req = 1'b0;
        tick();
        rst_in = 1'b0;
        tick();
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h20;
        g = cyc + 1;
        push(1'b0, 1'b1, 32'h000000AB, g + 2);
        tick();
        check("arst_idle_a", mem_a, 32'h20);
        wait_done(seen + 1, "arst_wait");
        ls_req = 1'b0;
        idle(6);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory controller sharing the byte-wide RAM bus between instruction fetch (IF) and the load/store buffer (LSB). Accepts one 32-bit-addressed request at a time, serialises it into byte accesses, and returns assembled read data or a store-complete pulse. Sits between the IF/LSB units and the external RAM/IO port; its fetched words feed the instruction queue.

## Interface
- No parameters.
- clk_in  in  1  clock; all state on rising edge.
- rst_in  in  1  reset, asynchronous, active-high.
- rdy_in  in  1  global enable; 0 freezes all state.
- clear  in  1  misprediction flush, synchronous.
- io_buffer_full  in  1  IO write buffer full.
- mem_din  in  8  RAM read byte, valid the cycle after its address.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1 = write, 0 = read.
- if_req  in  1  IF fetch request, held until if_done.
- if_addr  in  32  fetch address.
- if_done  out  1  one-cycle pulse, if_data valid.
- if_data  out  32  fetched word, little-endian.
- ls_req  in  1  LSB request, held until ls_done.
- ls_wr  in  1  1 = store, 0 = load.
- ls_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and is treated as word.
- ls_addr  in  32  access address.
- ls_wdata  in  32  store data; low bytes used.
- ls_done  out  1  one-cycle pulse, load data valid / store complete.
- ls_rdata  out  32  load data, zero-extended; sign extension is done by the LSB.

## Operation
- States: IDLE, READ, WRITE.
- Reset values: state IDLE, last_grant = IF, mem_a = 0, mem_dout = 0, mem_wr = 0, if_done = 0, ls_done = 0, if_data = 0, ls_rdata = 0.
- Arbitration happens in IDLE only.
  - If exactly one request is present, grant it.
  - If both are present, grant the requester not equal to last_grant; last_grant updates on every grant.
  - After reset, therefore, LSB wins the first tie.
- Requests are not sampled on an edge where if_done or ls_done is high. This gives one bubble between operations.
- Byte count N: 4 for IF; 1, 2 or 4 for LSB per ls_size.
- Byte i uses address addr+i, computed modulo 2^32. Alignment is not checked.
- READ:
  - Present addr+i for i = 0..N-1 on consecutive cycles.
  - Capture mem_din into byte lane i one cycle after its address.
  - After the last capture, return to IDLE and pulse done with the assembled data; unused upper lanes are 0.
- WRITE (LSB only):
  - Present addr+i with mem_dout = ls_wdata byte i and mem_wr = 1 for i = 0..N-1.
  - Then pulse ls_done, force mem_wr = 0 and return to IDLE.
- IO stall: in WRITE, if addr[17:16] = 2'b11 and io_buffer_full = 1, hold the current byte with mem_wr = 0 and do not advance i until io_buffer_full = 0.
- clear = 1 at an edge:
  - An active READ (fetch or load) aborts: state goes to IDLE with no done pulse and mem_wr = 0.
  - An active WRITE continues to completion.
  - No new grant is made on that edge.
- rdy_in = 0: every register holds, including the counter, the outputs and the done pulse. clear and requests are ignored.

## Timing
- Edge 0 is the grant edge, at which the request is sampled in IDLE. After edge 0, mem_a = addr.
- N-byte read:
  - Address for byte i is on the bus after edge i.
  - Byte i is captured at edge i+2.
  - done is high in the cycle after edge N+1.
  - A word read gives done after edge 5; a byte load gives done after edge 2.
- N-byte write:
  - Byte i is on the bus with mem_wr = 1 after edge i.
  - ls_done is high after edge N, with mem_wr = 0.
  - Each IO stall cycle adds one cycle.
- Done pulses last exactly one enabled cycle.
- Minimum spacing between grants is latency + 1 bubble.
- Reset asserted mid-operation clears everything immediately, with no done pulse.

## Test plan
- Word fetch: RAM[0x100..0x103] = 13,00,50,00; if_addr = 0x100 -> mem_a = 0x100..0x103 on consecutive cycles, if_done after edge 5, if_data = 0x00500013.
- Byte store then half load: ls_wr = 1, size 0, addr 0x20, wdata 0xAB -> one mem_wr = 1 cycle with mem_dout = 0xAB, ls_done after edge 1. Then size 1 load at 0x20 with RAM[0x21] = 0xCD -> ls_rdata = 0x0000CDAB after edge 3.
- Tie: if_req and ls_req both asserted from reset -> LSB granted first, IF second. With both held asserted, grants alternate.
- Flush: clear = 1 two cycles into a fetch -> no if_done, IDLE next cycle. Clear during a 4-byte store -> all 4 bytes written, ls_done still pulses.
- IO stall: store byte to 0x30000 with io_buffer_full = 1 for 3 cycles -> mem_wr = 0 for those cycles, write issues after, ls_done 3 cycles late.
- rdy_in = 0 for 2 cycles mid-fetch, then async reset mid-store -> latency +2 cycles with correct data; after reset, outputs are 0 and state is IDLE immediately.
